// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_tx
//  Description : Serializes a 10-bit frame {stop, parity, data[7:0]} behind a
//                start bit, LSB first, onto TXD at CLK/CLK_DIV baud. Frame bits
//                are sent verbatim so injected parity/stop errors reach the line.
//                Optional macro UART_TX_TWO_STOP_EN appends a second stop period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_tx #(
   parameter int CLK_DIV = 868,
   parameter int FRAME_W = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [FRAME_W-1:0] FRAME,
   input  logic               START,
   output logic               BUSY,
   output logic               TXD,
   output logic               DONE
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_W - 1);

`ifdef UART_TX_TWO_STOP_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP2 = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2
   } state_t;
`endif

   state_t               state,      state_nxt;
   logic [CNT_W-1:0]     baud_cnt,   baud_cnt_nxt;
   logic [3:0]           bit_idx,    bit_idx_nxt;
   logic [FRAME_W-1:0]   shift_reg,  shift_reg_nxt;
   logic                 txd_q,      txd_nxt;
   logic                 busy_q,     busy_nxt;
   logic                 done_q,     done_nxt;
   logic                 bit_end;

   assign bit_end = (baud_cnt == CNT_LAST);
   assign TXD     = txd_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;

   // State and all outputs are registered so TXD never glitches.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '1;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift_reg <= shift_reg_nxt;
         txd_q     <= txd_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
      end
   end

   // Next-state logic; outputs are computed one cycle ahead of the line.
   always_comb begin
      state_nxt     = state;
      baud_cnt_nxt  = baud_cnt;
      bit_idx_nxt   = bit_idx;
      shift_reg_nxt = shift_reg;
      txd_nxt       = txd_q;
      busy_nxt      = busy_q;
      done_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            baud_cnt_nxt = '0;
            bit_idx_nxt  = '0;
            txd_nxt      = 1'b1;
            busy_nxt     = 1'b0;
            if (START) begin
               shift_reg_nxt = FRAME;
               state_nxt     = S_START;
               txd_nxt       = 1'b0;
               busy_nxt      = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = S_DATA;
               txd_nxt      = shift_reg[0];
            end else begin
               baud_cnt_nxt = baud_cnt + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_cnt_nxt  = '0;
               shift_reg_nxt = {1'b1, shift_reg[FRAME_W-1:1]};
               if (bit_idx == LAST_BIT) begin
                  txd_nxt = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                  state_nxt = S_STOP2;
`else
                  state_nxt = S_IDLE;
                  busy_nxt  = 1'b0;
`endif
               end else begin
                  // Index stops at the last bit; IDLE clears it for the next frame.
                  bit_idx_nxt = bit_idx + 4'd1;
                  txd_nxt     = shift_reg[1];
               end
            end else begin
               baud_cnt_nxt = baud_cnt + CNT_W'(1);
`ifndef UART_TX_TWO_STOP_EN
               // Registered pulse lands in the final clock of the last bit.
               if ((bit_idx == LAST_BIT) && (baud_cnt == CNT_PRE))
                  done_nxt = 1'b1;
`endif
            end
         end

`ifdef UART_TX_TWO_STOP_EN
         S_STOP2: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = S_IDLE;
               busy_nxt     = 1'b0;
               txd_nxt      = 1'b1;
            end else begin
               baud_cnt_nxt = baud_cnt + CNT_W'(1);
               if (baud_cnt == CNT_PRE)
                  done_nxt = 1'b1;
            end
         end
`endif

         default: begin
            state_nxt = S_IDLE;
            txd_nxt   = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_tx
//  Description : Self-checking bench for uart_frame_tx at CLK_DIV=4. The line
//                is predicted clock by clock from the frame bit list.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_tx;

   localparam int CLK_DIV = 4;
`ifdef UART_TX_TWO_STOP_EN
   localparam int NBITS = 12;
`else
   localparam int NBITS = 11;
`endif
   localparam int LEN = NBITS * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] frame;
   logic       busy, txd, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_frame_tx #(.CLK_DIV(CLK_DIV), .FRAME_W(10)) dut (
      .CLK(clk), .RST(rst), .FRAME(frame), .START(start),
      .BUSY(busy), .TXD(txd), .DONE(done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Line level k clocks after acceptance: start bit, 10 frame bits, then 1s.
   function automatic logic exp_txd(input logic [9:0] f, input int k);
      int b;
      b = (k - 1) / CLK_DIV;
      if (b == 0)  return 1'b0;
      if (b <= 10) return f[b-1];
      return 1'b1;
   endfunction

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; frame = '0;
      tick; tick;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got txd=%b busy=%b done=%b exp 1 0 0", txd, busy, done);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         checks++;
         if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle clk=%0d got txd=%b busy=%b done=%b exp 1 0 0", i, txd, busy, done);
         end
      end
   endtask

   // Single frames; START/FRAME are scrambled while busy and must be ignored.
   task automatic test_frames;
      logic [9:0] list [0:9];
      logic [9:0] f;
      list[0] = 10'b1_0_01010101;
      list[1] = 10'b0_1_11111111;
      list[2] = 10'h3FF;
      list[3] = 10'h000;
      for (int i = 4; i < 10; i++) list[i] = 10'($urandom);
      for (int n = 0; n < 10; n++) begin
         f = list[n];
         start = 1'b1; frame = f;
         tick;
         start = 1'b0;
         for (int k = 1; k <= LEN; k++) begin
            checks++;
            if (txd !== exp_txd(f, k) || busy !== 1'b1 || done !== (k == LEN)) begin
               errors++;
               $display("FAIL frame f=%h k=%0d got txd=%b busy=%b done=%b exp %b 1 %b",
                        f, k, txd, busy, done, exp_txd(f, k), (k == LEN));
            end
            start = 1'($urandom);
            frame = 10'($urandom);
            tick;
         end
         start = 1'b0;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
               errors++;
               $display("FAIL frame_end f=%h k=%0d got txd=%b busy=%b done=%b exp 1 0 0",
                        f, k, txd, busy, done);
            end
            tick;
         end
      end
   endtask

   // START held high: exactly one idle-high clock between consecutive frames.
   task automatic test_back_to_back;
      logic [9:0] f;
      f = 10'h2A5;
      start = 1'b1; frame = f;
      tick;
      for (int r = 0; r < 3; r++) begin
         for (int k = 1; k <= LEN; k++) begin
            checks++;
            if (txd !== exp_txd(f, k) || busy !== 1'b1 || done !== (k == LEN)) begin
               errors++;
               $display("FAIL b2b r=%0d k=%0d got txd=%b busy=%b done=%b exp %b 1 %b",
                        r, k, txd, busy, done, exp_txd(f, k), (k == LEN));
            end
            tick;
         end
         checks++;
         if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap r=%0d got txd=%b busy=%b done=%b exp 1 0 0", r, txd, busy, done);
         end
         if (r == 2) start = 1'b0;
         tick;
      end
      checks++;
      if (busy !== 1'b0 || txd !== 1'b1) begin
         errors++;
         $display("FAIL b2b_stop got busy=%b txd=%b exp 0 1", busy, txd);
      end
   endtask

   // Reset during clock 17 aborts the frame; the next frame is intact.
   task automatic test_mid_reset;
      logic [9:0] f;
      f = 10'($urandom);
      start = 1'b1; frame = f;
      tick;
      start = 1'b0;
      for (int k = 1; k < 17; k++) tick;
      checks++;
      if (txd !== exp_txd(f, 17) || busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset got txd=%b busy=%b exp %b 1", txd, busy, exp_txd(f, 17));
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got txd=%b busy=%b done=%b exp 1 0 0", txd, busy, done);
      end
      for (int k = 0; k < LEN; k++) begin
         tick;
         checks++;
         if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset k=%0d got txd=%b busy=%b done=%b exp 1 0 0", k, txd, busy, done);
         end
      end
      f = 10'($urandom);
      start = 1'b1; frame = f;
      tick;
      start = 1'b0;
      for (int k = 1; k <= LEN + 1; k++) begin
         checks++;
         if (k <= LEN) begin
            if (txd !== exp_txd(f, k) || busy !== 1'b1 || done !== (k == LEN)) begin
               errors++;
               $display("FAIL resume f=%h k=%0d got txd=%b busy=%b done=%b exp %b 1 %b",
                        f, k, txd, busy, done, exp_txd(f, k), (k == LEN));
            end
         end else if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL resume_end got txd=%b busy=%b done=%b exp 1 0 0", txd, busy, done);
         end
         tick;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; frame = '0;
      test_reset;
      test_frames;
      test_back_to_back;
      test_mid_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Serializer directly downstream of the error-injection stage.
- Accepts a 10-bit frame {stop, parity, data[7:0]}, prepends a start bit (0) and shifts the frame out LSB-first on a single TXD line at a fixed baud rate set by a clock divider.
- Transmits frame bits exactly as presented, including a corrupted parity or stop bit, so that injected errors reach the line unchanged for receiver testing.

Parameters:
- CLK_DIV, 868, clock cycles per bit period (100 MHz / 115200 baud); legal range is 2 or more.
- FRAME_W, 10, frame width in bits (data + parity + stop); fixed at 10 in this design.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- FRAME  input  10  frame to send: [7:0] data, [8] parity, [9] stop; sampled only on accept.
- START  input  1  request to send FRAME; accepted only when BUSY=0.
- BUSY  output  1  high while a frame is being transmitted.
- TXD  output  1  serial line; idles high.
- DONE  output  1  one-cycle pulse in the last clock of the final bit period.

Behaviour:
- Reset:
  - RST=1 at a clock edge forces the state to IDLE, TXD=1, BUSY=0, DONE=0.
  - The baud counter and bit index are cleared to 0 and the shift register to 0x3FF.
  - Reset mid-frame aborts the frame immediately: TXD=1 on the following cycle, and the partial frame is not resumed.
- States:
  - IDLE: TXD=1, BUSY=0. If START=1, latch FRAME into the shift register and go to START_BIT.
  - START_BIT: TXD=0 for CLK_DIV cycles, then go to DATA.
  - DATA: TXD = shift_reg[0] for CLK_DIV cycles per bit. After each bit period, shift right and increment the bit index.
    - After bit index 9 completes, return to IDLE (or go to STOP2 when the optional feature is enabled).
- Timing:
  - If START is sampled high in IDLE at edge N, then TXD=0 and BUSY=1 from edge N+1.
  - Each bit period is exactly CLK_DIV clocks.
  - Total frame length is 11*CLK_DIV clocks (12*CLK_DIV with the option).
  - DONE=1 during the final clock of the last bit period. On the next edge BUSY=0 and TXD=1.
- Back-to-back frames: the earliest next accept is the clock after DONE, which leaves one idle-high clock between frames.
- START while BUSY=1 is ignored; the request is not queued. FRAME changes during transmission have no effect.
- Baud counter:
  - Width is $clog2(CLK_DIV), counting 0..CLK_DIV-1 and wrapping to 0 at the end of each bit period.
  - The counter is held at 0 in IDLE.
- Bit index: 4 bits, range 0..9, with no wrap beyond 9.
- No checking or correction: FRAME[9]=0 is transmitted as 0 (framing error on the line), and FRAME[8] is sent verbatim.
- Outputs are registered; TXD is glitch-free.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: after the 10 frame bits, a STOP2 state drives TXD=1 for one extra CLK_DIV period. DONE moves to the last clock of STOP2, and the frame length becomes 12*CLK_DIV clocks.
- Undefined: no STOP2 state; the frame length is 11*CLK_DIV clocks and the state encoding omits STOP2.

Test Plan (CLK_DIV=4):
- Reset then idle 20 clocks -> TXD=1, BUSY=0, DONE=0 throughout.
- FRAME=10'b1_0_01010101, 1-clock START pulse -> TXD sequence sampled mid-bit is 0,1,0,1,0,1,0,1,0,0,1. BUSY is high for 44 clocks and DONE pulses once at clock 44.
- FRAME=10'b0_1_11111111 (stop bit forced low) -> the last bit on TXD is 0 for 4 clocks, and TXD returns to 1 after DONE.
- START held high continuously with FRAME=0x2A5 -> frames repeat with exactly one idle-high clock between them; no START is accepted while BUSY=1.
- RST asserted at clock 17 of a frame -> TXD=1 and BUSY=0 on the next cycle, no DONE pulse; a new START afterwards transmits a complete, correct frame.
- With UART_TX_TWO_STOP_EN defined, FRAME=0x3FF -> the frame spans 48 clocks, the final 8 clocks are TXD=1, and DONE arrives at clock 48.
